// File: rtl/msdf_dot_sched_pkg.sv
// Shared constants and types for the msdf_dot request scheduler.
// Holds the bank width, the token last-bit position and the FSM state encoding.
package msdf_dot_sched_pkg;

    localparam int unsigned NUM_BITS_PER_BANK = 4;
    localparam int unsigned TOKEN_LAST_BIT    = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } sched_state_e;

    // One output digit of msdf_dot: {last, digit[1:0]}
    typedef struct packed {
        logic       last;
        logic [1:0] digit;
    } res_digit_t;

endpackage

// File: rtl/msdf_id_fifo.sv
// Owner-ID FIFO for jobs in flight inside msdf_dot.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module msdf_id_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: a slot is only read after it was written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/msdf_dot_sched.sv
// Round-robin scheduler sharing one msdf_dot among NUM_REQ requesters.
// Grants one job at a time, forwards its tokens and routes result digits back by owner.
module msdf_dot_sched
    import msdf_dot_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned NB               = NUM_BITS_PER_BANK,
    parameter int unsigned TARGET_PRECISION = 25,
    parameter int unsigned MAX_INFLIGHT     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ*3*NB-1:0]      req_data_0,
    input  logic [NUM_REQ*3*NB-1:0]      req_data_1,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [3*NB-1:0]              dot_data_0,
    output logic [3*NB-1:0]              dot_data_1,
    output logic                         dot_valid,
    input  logic                         dot_ready_0,
    input  logic                         dot_ready_1,
    input  logic [2:0]                   dot_out,
    input  logic                         dot_out_valid,
    output logic                         dot_out_ready,
    output logic [2:0]                   res_data,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
    output logic [NUM_REQ-1:0]           res_valid,
    input  logic [NUM_REQ-1:0]           res_ready,
    output logic                         busy,
    output logic                         err
);

    localparam int unsigned DW  = 3 * NB;
    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(TARGET_PRECISION + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(TARGET_PRECISION - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(TARGET_PRECISION);

    sched_state_e   state;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] arb_pick;
    logic           arb_found;
    logic [CW-1:0]  dig_cnt;
    logic           fifo_full;
    logic           fifo_empty;
    logic [IDW-1:0] head;
    logic           push;
    logic           pop;
    logic           xfer;
    logic           tok_last;
    logic           len_err;
    logic           orphan;
    res_digit_t     out_dig;

    // First valid requester at or above rr_ptr, wrapping around
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = rr_ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!arb_found && req_valid[rr_ptr + IDW'(i)]) begin
                arb_found = 1'b1;
                arb_pick  = rr_ptr + IDW'(i);
            end
        end
    end

    assign out_dig  = dot_out;
    assign push     = (state == IDLE) && arb_found && !fifo_full;
    assign xfer     = (state == STREAM) && req_valid[gnt] && dot_ready_0 && dot_ready_1;
    assign tok_last = req_data_1[DW*gnt + TOKEN_LAST_BIT];
    assign pop      = !fifo_empty && dot_out_valid && res_ready[head] && out_dig.last;
    assign len_err  = xfer && (tok_last ? (dig_cnt != LAST_IDX) : (dig_cnt == LAST_IDX));
    assign orphan   = fifo_empty && dot_out_valid;
    assign busy     = (state == STREAM) || !fifo_empty;

    // Forward path: granted requester's tokens straight to the dot unit
    always_comb begin
        dot_data_0 = '0;
        dot_data_1 = '0;
        dot_valid  = 1'b0;
        req_ready  = '0;
        if (state == STREAM) begin
            dot_data_0     = req_data_0[DW*gnt +: DW];
            dot_data_1     = req_data_1[DW*gnt +: DW];
            dot_valid      = req_valid[gnt];
            req_ready[gnt] = dot_ready_0 & dot_ready_1;
        end
    end

    // Return path: digits go to the owner at the FIFO head
    always_comb begin
        res_data      = '0;
        res_id        = '0;
        res_valid     = '0;
        dot_out_ready = 1'b0;
        if (!fifo_empty) begin
            res_data        = out_dig;
            res_id          = head;
            res_valid[head] = dot_out_valid;
            dot_out_ready   = res_ready[head];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gnt     <= '0;
            rr_ptr  <= '0;
            dig_cnt <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        gnt     <= arb_pick;
                        dig_cnt <= '0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        // Saturate so an overlong job cannot wrap back to a legal count
                        if (dig_cnt != MAX_CNT) dig_cnt <= dig_cnt + CW'(1);
                        if (tok_last) begin
                            rr_ptr <= gnt + IDW'(1);
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (len_err || orphan) err <= 1'b1;
        end
    end

    msdf_id_fifo #(
        .W     (IDW),
        .DEPTH (MAX_INFLIGHT)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (arb_pick),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

endmodule

// File: tb/tb_msdf_dot_sched.sv
// Self-checking bench for msdf_dot_sched: grant table, randomized traffic against
// a job-level scoreboard, and hand sequences for in-flight limit, errors and reset.
module tb_msdf_dot_sched;
    import msdf_dot_sched_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned NB = NUM_BITS_PER_BANK;
    localparam int unsigned DW = 3 * NB;
    localparam int unsigned TP = 25;
    localparam int unsigned MI = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NR*DW-1:0] req_data_0, req_data_1;
    logic [NR-1:0]    req_valid, req_ready, res_valid, res_ready;
    logic [DW-1:0]    dot_data_0, dot_data_1;
    logic             dot_valid, dot_ready_0, dot_ready_1;
    logic [2:0]       dot_out, res_data;
    logic             dot_out_valid, dot_out_ready;
    logic [1:0]       res_id;
    logic             busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    // Environment results, inspected after each run_env call
    int starts[$];
    int n_xfer;
    int res_cnt[NR];

    always #5 clk = ~clk;

    msdf_dot_sched #(
        .NUM_REQ          (NR),
        .NB               (NB),
        .TARGET_PRECISION (TP),
        .MAX_INFLIGHT     (MI)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_data_0    (req_data_0),
        .req_data_1    (req_data_1),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .dot_data_0    (dot_data_0),
        .dot_data_1    (dot_data_1),
        .dot_valid     (dot_valid),
        .dot_ready_0   (dot_ready_0),
        .dot_ready_1   (dot_ready_1),
        .dot_out       (dot_out),
        .dot_out_valid (dot_out_valid),
        .dot_out_ready (dot_out_ready),
        .res_data      (res_data),
        .res_id        (res_id),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .busy          (busy),
        .err           (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] tok0(input int r, input int j, input int d);
        logic [11:0] t;
        t = {2'(r), 5'(d), 5'(j)};
        return DW'(t);
    endfunction

    function automatic logic [DW-1:0] tok1(input int r, input int j, input int d, input bit last);
        logic [11:0] t;
        t = {4'(j), 2'(r), 3'(d >> 2), last, 2'(d)};
        return DW'(t);
    endfunction

    task automatic set_tok(input int r, input int j, input int d, input bit last, input bit v);
        req_data_0[r*DW +: DW] = tok0(r, j, d);
        req_data_1[r*DW +: DW] = tok1(r, j, d, last);
        req_valid[r]           = v;
    endtask

    task automatic idle_inputs();
        req_data_0    = '0;
        req_data_1    = '0;
        req_valid     = '0;
        dot_ready_0   = 1'b1;
        dot_ready_1   = 1'b1;
        dot_out       = '0;
        dot_out_valid = 1'b0;
        res_ready     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        rst = 1'b1;
    endtask

    // Grant then stream one job of n digits from requester r, all readies high
    task automatic hand_job(input int r, input int j, input int n);
        idle_inputs();
        set_tok(r, j, 0, n == 1, 1'b1);
        step();
        for (int d = 0; d < n; d++) begin
            set_tok(r, j, d, d == n - 1, 1'b1);
            step();
        end
        idle_inputs();
    endtask

    // Job-level environment: requesters stream TP-digit jobs; the dot model returns
    // one digit per accepted token, in job order, tagged with the owning requester.
    task automatic run_env(input int j0, input int j1, input int j2, input int j3,
                           input int vprob, input int rprob, input bit toggle_r1,
                           input int oprob, input int resprob, input bit gap_chk,
                           input int budget);
        int          jobs_left[NR];
        int          dig[NR];
        int          jidx[NR];
        logic [4:0]  outq[$];
        int          cur_owner;
        int          job_tok;
        int          last_cyc;
        int          owner;
        bit          done;
        logic [4:0]  e;
        jobs_left = '{j0, j1, j2, j3};
        for (int r = 0; r < NR; r++) begin
            dig[r]     = 0;
            jidx[r]    = 0;
            res_cnt[r] = 0;
        end
        starts.delete();
        outq.delete();
        n_xfer    = 0;
        cur_owner = -1;
        job_tok   = 0;
        last_cyc  = -1;
        done      = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (jobs_left[0] == 0 && jobs_left[1] == 0 && jobs_left[2] == 0 &&
                jobs_left[3] == 0 && outq.size() == 0 && cur_owner < 0) begin
                done = 1'b1;
                break;
            end
            for (int r = 0; r < NR; r++) begin
                if (jobs_left[r] > 0)
                    set_tok(r, jidx[r], dig[r], dig[r] == TP - 1, $urandom_range(99) < vprob);
                else
                    req_valid[r] = 1'b0;
            end
            dot_ready_0 = $urandom_range(99) < rprob;
            dot_ready_1 = toggle_r1 ? cyc[0] : ($urandom_range(99) < rprob);
            if (outq.size() > 0 && $urandom_range(99) < oprob) begin
                dot_out_valid = 1'b1;
                e             = outq[0];
                dot_out       = e[2:0];
            end else begin
                dot_out_valid = 1'b0;
                dot_out       = '0;
            end
            for (int r = 0; r < NR; r++) res_ready[r] = $urandom_range(99) < resprob;
            #1;
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (cur_owner >= 0) begin
                chk("ready_follows_and", 32'(req_ready),
                    32'(NR'(dot_ready_0 & dot_ready_1) << cur_owner));
                chk("dot_valid_follows", 32'(dot_valid), 32'(req_valid[cur_owner]));
            end
            for (int r = 0; r < NR; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    if (cur_owner < 0) begin
                        if (gap_chk && last_cyc >= 0) chk("job_gap", cyc - last_cyc, 2);
                        starts.push_back(r);
                        cur_owner = r;
                        job_tok   = 0;
                    end
                    chk("xfer_owner", r, cur_owner);
                    chk("dot_data_0", 32'(dot_data_0), 32'(tok0(r, jidx[r], dig[r])));
                    chk("dot_data_1", 32'(dot_data_1), 32'(tok1(r, jidx[r], dig[r], dig[r] == TP - 1)));
                    n_xfer++;
                    job_tok++;
                    if (dig[r] == TP - 1) begin
                        for (int i = 0; i < job_tok; i++)
                            outq.push_back({2'(r), 1'(i == job_tok - 1), 2'(r + i)});
                        jobs_left[r]--;
                        jidx[r]++;
                        dig[r]    = 0;
                        cur_owner = -1;
                        last_cyc  = cyc;
                    end else begin
                        dig[r]++;
                    end
                end
            end
            if (dot_out_valid) begin
                e     = outq[0];
                owner = int'(e[4:3]);
                chk("res_valid", 32'(res_valid), 32'(NR'(1) << owner));
                chk("res_id", 32'(res_id), owner);
                chk("res_data", 32'(res_data), 32'(e[2:0]));
                chk("dot_out_ready", 32'(dot_out_ready), 32'(res_ready[owner]));
                if (dot_out_ready) begin
                    void'(outq.pop_front());
                    res_cnt[owner]++;
                end
            end else begin
                chk("res_valid_idle", 32'(res_valid), 0);
            end
            step();
        end
        chk("env_done", 32'(done), 1);
        idle_inputs();
        #1;
        chk("env_busy_end", 32'(busy), 0);
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        int            exp_g;
    } gvec_t;

    gvec_t gtab[9];

    initial begin
        idle_inputs();

        // Grant table: requester masks seen in IDLE and the round-robin winner
        gtab[0] = '{4'b1111, 0};
        gtab[1] = '{4'b1111, 1};
        gtab[2] = '{4'b0001, 0};
        gtab[3] = '{4'b1001, 3};
        gtab[4] = '{4'b1000, 3};
        gtab[5] = '{4'b0110, 1};
        gtab[6] = '{4'b0011, 0};
        gtab[7] = '{4'b0100, 2};
        gtab[8] = '{4'b0111, 0};

        do_reset();
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_dot_valid", 32'(dot_valid), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_dot_out_ready", 32'(dot_out_ready), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);

        for (int k = 0; k < 9; k++) begin
            idle_inputs();
            req_valid = gtab[k].mask;
            #1;
            chk("tab_idle_ready", 32'(req_ready), 0);
            step();
            for (int r = 0; r < NR; r++) set_tok(r, k, 0, 1'b1, gtab[k].mask[r]);
            #1;
            chk("tab_grant", 32'(req_ready), 32'(NR'(1) << gtab[k].exp_g));
            chk("tab_dot_data", 32'(dot_data_0), 32'(tok0(gtab[k].exp_g, k, 0)));
            chk("tab_busy", 32'(busy), 1);
            step();
            idle_inputs();
            dot_out_valid = 1'b1;
            dot_out       = 3'b100;
            res_ready     = '1;
            #1;
            chk("tab_res_id", 32'(res_id), gtab[k].exp_g);
            step();
        end

        // Single job from requester 2
        do_reset();
        run_env(0, 0, 1, 0, 100, 100, 1'b0, 100, 100, 1'b0, 500);
        chk("single_res_cnt", res_cnt[2], TP);
        chk("single_xfer", n_xfer, TP);
        chk("single_err", 32'(err), 0);

        // Round-robin with everybody valid from reset
        do_reset();
        run_env(2, 1, 1, 1, 100, 100, 1'b0, 100, 100, 1'b1, 1000);
        for (int i = 0; i < 5; i++) chk("rr_order", (i < starts.size()) ? starts[i] : -1, i % NR);
        chk("rr_err", 32'(err), 0);

        // dot_ready_1 toggling every other cycle
        do_reset();
        run_env(0, 1, 0, 0, 100, 100, 1'b1, 100, 100, 1'b0, 500);
        chk("bp_xfer", n_xfer, TP);
        chk("bp_err", 32'(err), 0);

        // Random traffic
        do_reset();
        run_env(3, 3, 3, 3, 70, 70, 1'b0, 60, 60, 1'b0, 8000);
        chk("rnd_xfer", n_xfer, 12 * TP);
        for (int r = 0; r < NR; r++) chk("rnd_res_cnt", res_cnt[r], 3 * TP);
        chk("rnd_err", 32'(err), 0);

        // In-flight limit: four jobs with the dot output stalled
        do_reset();
        for (int r = 0; r < NR; r++) hand_job(r, 0, TP);
        req_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("full_no_grant", 32'(req_ready), 0);
            chk("full_busy", 32'(busy), 1);
            step();
        end
        dot_out_valid = 1'b1;
        dot_out       = 3'b100;
        res_ready     = '1;
        #1;
        chk("full_pop_id", 32'(res_id), 0);
        chk("full_pop_ready", 32'(dot_out_ready), 1);
        chk("full_pop_cycle", 32'(req_ready), 0);
        step();
        dot_out_valid = 1'b0;
        #1;
        chk("full_grant_cycle", 32'(req_ready), 0);
        step();
        #1;
        chk("full_after_pop", 32'(req_ready), 1);
        chk("full_err", 32'(err), 0);

        // Short job: last on the 10th digit
        do_reset();
        idle_inputs();
        set_tok(1, 0, 0, 1'b0, 1'b1);
        step();
        for (int d = 0; d < 10; d++) begin
            set_tok(1, 0, d, d == 9, 1'b1);
            #1;
            chk("short_err_before", 32'(err), 0);
            step();
        end
        chk("short_err_after", 32'(err), 1);

        // Long job: 25 digits without a last flag
        do_reset();
        idle_inputs();
        set_tok(3, 0, 0, 1'b0, 1'b1);
        step();
        for (int d = 0; d < TP; d++) begin
            set_tok(3, 0, d, 1'b0, 1'b1);
            #1;
            chk("long_err_before", 32'(err), 0);
            step();
        end
        chk("long_err_after", 32'(err), 1);

        // Orphan digit with the FIFO empty
        do_reset();
        dot_out_valid = 1'b1;
        dot_out       = 3'b001;
        res_ready     = '1;
        #1;
        chk("orphan_ready", 32'(dot_out_ready), 0);
        chk("orphan_res_valid", 32'(res_valid), 0);
        chk("orphan_err_before", 32'(err), 0);
        step();
        chk("orphan_err_after", 32'(err), 1);
        dot_out_valid = 1'b0;
        step();
        chk("orphan_err_sticky", 32'(err), 1);

        // Reset in the middle of a job
        do_reset();
        hand_job(0, 0, TP);
        set_tok(1, 0, 0, 1'b0, 1'b1);
        step();
        for (int d = 0; d < 3; d++) begin
            set_tok(1, 0, d, 1'b0, 1'b1);
            step();
        end
        dot_out_valid = 1'b1;
        dot_out       = 3'b011;
        res_ready     = '1;
        #1;
        chk("midrst_pre_ready", 32'(req_ready), 32'(4'b0010));
        chk("midrst_pre_res_valid", 32'(res_valid), 32'(4'b0001));
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 0);
        chk("midrst_dot_valid", 32'(dot_valid), 0);
        chk("midrst_res_valid", 32'(res_valid), 0);
        chk("midrst_dot_out_ready", 32'(dot_out_ready), 0);
        chk("midrst_res_data", 32'(res_data), 0);
        chk("midrst_res_id", 32'(res_id), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_err", 32'(err), 0);
        dot_out_valid = 1'b0;
        req_valid     = '1;
        step();
        rst = 1'b1;
        #1;
        chk("midrst_idle", 32'(req_ready), 0);
        step();
        chk("midrst_regrant", 32'(req_ready), 32'(4'b0001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msdf_dot_sched.md
# msdf_dot_sched

Round-robin scheduler that shares one `msdf_dot` unit among `NUM_REQ` requesters. Each requester streams a job: one operand-pair token per digit, ending with a last-flagged digit. The block grants the dot unit to one requester per job, forwards that job's input tokens, and records the owner ID in an in-flight FIFO. It then routes the dot unit's 3-bit output digit stream back to the owning requester, which lets several jobs be in the dot pipeline at once.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; power of two, ≥2.
- `NB`, `` `NUM_BITS_PER_BANK ``: banks per operand. Each token is `3*NB` bits per operand.
- `TARGET_PRECISION`, 25: required digits per job.
- `MAX_INFLIGHT`, 4: depth of the owner-ID FIFO; power of two.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `req_data_0` in `NUM_REQ*3*NB`: operand-0 token of requester r, at slice r.
- `req_data_1` in `NUM_REQ*3*NB`: operand-1 token of requester r. Bit 2 of bank 0 is the last flag.
- `req_valid` in `NUM_REQ`: one token pair valid, per requester.
- `req_ready` out `NUM_REQ`: token pair accepted, per requester.
- `dot_data_0` out `3*NB`: to `msdf_dot` `dataInArray_0`.
- `dot_data_1` out `3*NB`: to `msdf_dot` `dataInArray_1`.
- `dot_valid` out 1: drives both `msdf_dot` `pValidArray_0/1`.
- `dot_ready_0` in 1: from `msdf_dot` `readyArray_0`.
- `dot_ready_1` in 1: from `msdf_dot` `readyArray_1`.
- `dot_out` in 3: `msdf_dot` `dataOutArray_0`, as {last, digit[1:0]}.
- `dot_out_valid` in 1: `msdf_dot` `validArray_0`.
- `dot_out_ready` out 1: `msdf_dot` `nReadyArray_0`.
- `res_data` out 3: result digit (shared bus).
- `res_id` out `$clog2(NUM_REQ)`: owner of `res_data`.
- `res_valid` out `NUM_REQ`: one-hot result valid.
- `res_ready` in `NUM_REQ`: per-requester result ready.
- `busy` out 1: state STREAM, or FIFO not empty.
- `err` out 1: sticky protocol error.

## Operation
- FSM states are IDLE and STREAM. Reset puts the FSM in IDLE with `rr_ptr`=0 and the FIFO empty.
- IDLE, grant condition: any `req_valid` set and the FIFO not full.
  - Grant `g` = first set `req_valid` searching upward from `rr_ptr`, with wrap-around.
  - Register `g`, push `g` into the FIFO, clear `dig_cnt`, and go to STREAM.
  - No token transfers in IDLE.
- STREAM, forwarding:
  - `dot_data_*` = slice `g` of `req_data_*`.
  - `dot_valid` = `req_valid[g]`.
  - `req_ready[g]` = `dot_ready_0 & dot_ready_1`. All other `req_ready` bits are 0.
- STREAM, transfer: a transfer occurs when `req_valid[g] & dot_ready_0 & dot_ready_1`. Each transfer increments `dig_cnt`.
- STREAM, end of job: a transfer with the last flag set sets `rr_ptr`=`g`+1 (mod `NUM_REQ`) and returns the FSM to IDLE.
- Length check: `err` is set if a last-flagged transfer happens with `dig_cnt` ≠ `TARGET_PRECISION`−1, or if `dig_cnt` reaches `TARGET_PRECISION` without a last flag. The job still ends only on the last flag.
- Result routing, FIFO not empty (head = `h`):
  - `res_data` = `dot_out`, `res_id` = `h`.
  - `res_valid[h]` = `dot_out_valid`.
  - `dot_out_ready` = `res_ready[h]`.
  - The FIFO pops on a transfer whose `dot_out[2]`=1.
- Result routing, FIFO empty: `dot_out_ready`=0 and all `res_valid` are 0. If `dot_out_valid`=1 in this condition, `err` is set (orphan digit).
- Push and pop in the same cycle are both performed, so the occupancy is unchanged.
- `err` clears only on reset.

## Timing
- Reset values: `req_ready`=0, `dot_valid`=0, `res_valid`=0, `dot_out_ready`=0, `res_data`=0, `res_id`=0, `busy`=0, `err`=0.
- Grant latency is 1 cycle: a request seen in IDLE at cycle n can transfer at cycle n+1 at the earliest.
- Back-to-back jobs have a gap of at least 1 cycle (the IDLE cycle after the last digit).
- Forward and return paths are combinational: 0 added latency, no registers in the data paths.
- `dot_valid` must not depend on `dot_ready_*`. `req_ready` may depend on `dot_ready_*`.
- A mid-job `req_valid` drop stalls the job without losing the grant.
- When the FIFO is full, no new grant is made until a pop; a pop in the same IDLE cycle does not enable the grant.
- Reset mid-job: all state clears immediately. Digits already inside `msdf_dot` are the system reset's responsibility.

## Structure
- `define.vh` holds `` `NUM_BITS_PER_BANK ``, the token last-bit index (2), and the FSM state encodings (IDLE=0, STREAM=1).
- Sub-module `msdf_id_fifo`: a synchronous FIFO of width `$clog2(NUM_REQ)` and depth `MAX_INFLIGHT`.
  - Provides push, pop, full, empty and head.
  - Pointers are one bit wider than the address, for full/empty detection.
  - Resets asynchronously on `rst` low.
- Everything else (FSM, round-robin arbiter, counter, muxes) lives in `msdf_dot_sched`.

## Test plan
- Single job: requester 2 sends 25 pairs (last on the 25th), with the dot model returning 25 digits. Required: `res_valid[2]` pulses 25 times, `res_id`=2, and `err`=0.
- Round-robin: all 4 requesters valid from reset. Required grant order 0,1,2,3,0, with one IDLE cycle between jobs.
- In-flight limit: the dot output is held stalled while 4 jobs are sent. Required: a fifth request gets no `req_ready` until the first last-flagged output is popped.
- Backpressure: toggle `dot_ready_1` every other cycle. Required: `req_ready[g]` follows the AND of both readies, and the dot model sees exactly 25 transfers.
- Length error: a job with last on digit 10 sets `err`=1 at that transfer. An output digit arriving while the FIFO is empty also sets `err`=1.
- Reset: assert `rst` low mid-STREAM. Required: all outputs return to 0 immediately, and after release the grant restarts from requester 0.
